out_stream_ctrl: RTL and testbench

Sequences the downsampled-pixel output path of the processor. It captures core stores to the memory-mapped output address, buffers them in a small FIFO and drains them to an external pixel sink over valid/ready. It back-pressures the core with a stall, counts delivered pixels and flags frame completion. It sits between the core's IRAM write port and the frame sink or capture logic.

---
 rtl/out_stream_pkg.sv | 17 +
 rtl/out_stream_fifo.sv | 66 ++++++
 rtl/out_stream_ctrl.sv | 132 +++++++++++++
 tb/tb_out_stream_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_stream_pkg.sv
// rtl/out_stream_pkg.sv - shared state encoding and default sizes for the output pixel stream
// No ports; imported by out_stream_ctrl and out_stream_fifo.
package out_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_OUT_ADDR = 80;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/out_stream_fifo.sv
// rtl/out_stream_fifo.sv - synchronous pixel FIFO, head word presented combinationally
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   push, wdata        write one word (ignored when full)
//   pop                retire the head word (ignored when empty)
//   rdata              head word
//   full, empty        occupancy flags
module out_stream_fifo
    import out_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              wr_en;
    logic              rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage is cleared on reset so the head word reads zero out of reset.
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_stream_ctrl.sv
// rtl/out_stream_ctrl.sv - captures core stores to the output port, buffers and streams pixels to a sink
// Ports:
//   clock, reset                    rising-edge clock, async active-high reset
//   start                           one-cycle frame start pulse
//   wren, IRAM_address, data        core write port
//   stall                           core must hold its write while high
//   out_valid, out_data, out_ready  pixel stream to the sink
//   pixel_count                     pixels delivered this frame (saturates at FRAME_PIXELS)
//   frame_done                      high while in DONE
//   drop_err                        sticky: output write seen outside STREAM
//   checksum                        only with OUT_STREAM_CHECKSUM_EN: mod-2^16 sum of delivered pixels
module out_stream_ctrl
    import out_stream_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int OUT_ADDR     = DEF_OUT_ADDR,
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_PIXELS = 16384,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              wren,
    input  logic [ADDR_W-1:0] IRAM_address,
    input  logic [DATA_W-1:0] data,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  pixel_count,
    output logic              frame_done,
    output logic              drop_err
`ifdef OUT_STREAM_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [CNT_W-1:0] FRAME_N = CNT_W'(FRAME_PIXELS);

    state_t           state;
    state_t           state_next;
    logic             hit;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             start_ok;
    logic [CNT_W-1:0] pushed_count;
    logic [CNT_W-1:0] pushed_next;

    assign hit         = wren && (IRAM_address == ADDR_W'(OUT_ADDR));
    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign push        = hit && (state == STREAM) && !full;
    // Stall depends on occupancy alone: a same-cycle pop does not open a slot.
    assign stall       = hit && (state == STREAM) && full;
    assign out_valid   = !empty;
    assign pop         = out_valid && out_ready;
    assign frame_done  = (state == DONE);
    assign pushed_next = pushed_count + 1'b1;

    out_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (data),
        .rdata (out_data),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (push && (pushed_next == FRAME_N)) state_next = DRAIN;
            DRAIN:   if (empty && (pixel_count == FRAME_N)) state_next = DONE;
            DONE:    if (start) state_next = STREAM;
            default: state_next = IDLE;
        endcase
    end

    // An accepted start takes priority over a stray hit in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pushed_count <= '0;
            pixel_count  <= '0;
            drop_err     <= 1'b0;
        end else if (start_ok) begin
            pushed_count <= '0;
            pixel_count  <= '0;
            drop_err     <= 1'b0;
        end else begin
            if (push) begin
                pushed_count <= pushed_next;
            end
            if (pop && (pixel_count != FRAME_N)) begin
                pixel_count <= pixel_count + 1'b1;
            end
            if (hit && (state != STREAM)) begin
                drop_err <= 1'b1;
            end
        end
    end

`ifdef OUT_STREAM_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + 16'(out_data);
        end
    end
`endif

endmodule

// File: tb/tb_out_stream_ctrl.sv
// tb/tb_out_stream_ctrl.sv - directed self-checking bench for out_stream_ctrl
module tb_out_stream_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic        wren;
    logic [7:0]  IRAM_address;
    logic [7:0]  data;
    logic        stall;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [15:0] pixel_count;
    logic        frame_done;
    logic        drop_err;
`ifdef OUT_STREAM_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int checks;
    int failures;

    out_stream_ctrl #(
        .DATA_W       (8),
        .ADDR_W       (8),
        .OUT_ADDR     (80),
        .FIFO_DEPTH   (4),
        .FRAME_PIXELS (8),
        .CNT_W        (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .wren         (wren),
        .IRAM_address (IRAM_address),
        .data         (data),
        .stall        (stall),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .pixel_count  (pixel_count),
        .frame_done   (frame_done),
        .drop_err     (drop_err)
`ifdef OUT_STREAM_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 20; n++) begin
            if (frame_done) break;
            tick();
        end
        chk(tag, 32'(frame_done), 32'd1);
    endtask

    // Steady one-in/one-out frame: each pixel is at the head one cycle after
    // its push, and the previous pixel pops on that same edge.
    task automatic steady_frame(input string tag, input int base);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wren         = 1'b1;
            IRAM_address = 8'd80;
            data         = 8'(base + i);
            #1;
            chk({tag, "_stall"}, 32'(stall), 32'd0);
            tick();
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"}, 32'(out_data), 32'(base + i));
            chk({tag, "_count"}, 32'(pixel_count), 32'(i - 1));
        end
        wren = 1'b0;
        wait_done({tag, "_done"});
        chk({tag, "_final_count"}, 32'(pixel_count), 32'd8);
        chk({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        start        = 1'b0;
        wren         = 1'b0;
        IRAM_address = '0;
        data         = '0;
        out_ready    = 1'b0;

        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_count", 32'(pixel_count), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        tick();

        // Stray write in IDLE
        wren = 1'b1; IRAM_address = 8'd80; data = 8'd5;
        #1;
        chk("idle_hit_stall", 32'(stall), 32'd0);
        tick();
        wren = 1'b0;
        #1;
        chk("idle_hit_drop", 32'(drop_err), 32'd1);
        chk("idle_hit_valid", 32'(out_valid), 32'd0);

        // Frame 1: always-ready sink, data 1..8
        do_start();
        #1;
        chk("start_clears_drop", 32'(drop_err), 32'd0);
        steady_frame("f1", 0);
`ifdef OUT_STREAM_CHECKSUM_EN
        chk("f1_checksum", 32'(checksum), 32'd36);
`endif

        // Stray write in DONE
        wren = 1'b1; IRAM_address = 8'd80; data = 8'd77;
        #1;
        chk("done_hit_stall", 32'(stall), 32'd0);
        tick();
        wren = 1'b0;
        #1;
        chk("done_hit_drop", 32'(drop_err), 32'd1);
        chk("done_hit_valid", 32'(out_valid), 32'd0);
        chk("done_level", 32'(frame_done), 32'd1);

        // Restart from DONE
        do_start();
        #1;
        chk("restart_done_low", 32'(frame_done), 32'd0);
        chk("restart_count", 32'(pixel_count), 32'd0);
        chk("restart_drop", 32'(drop_err), 32'd0);

        // Non-output address in STREAM
        out_ready = 1'b0;
        wren = 1'b1; IRAM_address = 8'd81; data = 8'd99;
        tick();
        wren = 1'b0;
        #1;
        chk("addr81_valid", 32'(out_valid), 32'd0);
        chk("addr81_drop", 32'(drop_err), 32'd0);

        // Backpressure: fill four entries, fifth write stalls
        for (int i = 0; i < 4; i++) begin
            wren = 1'b1; IRAM_address = 8'd80; data = 8'(10 + i);
            #1;
            chk("bp_fill_stall", 32'(stall), 32'd0);
            tick();
        end
        data = 8'd14;
        #1;
        chk("bp_stall_on", 32'(stall), 32'd1);
        tick();
        chk("bp_stall_held", 32'(stall), 32'd1);
        chk("bp_head_stable", 32'(out_data), 32'd10);
        chk("bp_count0", 32'(pixel_count), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_stall_full", 32'(stall), 32'd1);
        tick();
        chk("bp_stall_drop", 32'(stall), 32'd0);
        chk("bp_head11", 32'(out_data), 32'd11);
        chk("bp_count1", 32'(pixel_count), 32'd1);
        tick();
        wren = 1'b0;
        chk("bp_head12", 32'(out_data), 32'd12);
        chk("bp_count2", 32'(pixel_count), 32'd2);
        tick();
        chk("bp_head13", 32'(out_data), 32'd13);
        tick();
        chk("bp_head14", 32'(out_data), 32'd14);
        chk("bp_valid14", 32'(out_valid), 32'd1);
        chk("bp_count4", 32'(pixel_count), 32'd4);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_count5", 32'(pixel_count), 32'd5);

        // Finish frame 2 with three streamed pixels
        for (int i = 0; i < 3; i++) begin
            wren = 1'b1; IRAM_address = 8'd80; data = 8'(15 + i);
            #1;
            chk("f2_stall", 32'(stall), 32'd0);
            tick();
            chk("f2_data", 32'(out_data), 32'(15 + i));
            chk("f2_count", 32'(pixel_count), 32'(5 + i));
        end
        wren = 1'b0;
        wait_done("f2_done");
        chk("f2_final_count", 32'(pixel_count), 32'd8);

        // Reset mid-frame
        do_start();
        out_ready = 1'b1;
        wren = 1'b1; IRAM_address = 8'd80; data = 8'd1;
        tick();
        data = 8'd2;
        tick();
        out_ready = 1'b0;
        data = 8'd3;
        tick();
        data = 8'd4;
        tick();
        data = 8'd5;
        #1;
        chk("mid_count", 32'(pixel_count), 32'd1);
        chk("mid_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_count", 32'(pixel_count), 32'd0);
        chk("async_rst_done", 32'(frame_done), 32'd0);
        #1;
        reset = 1'b0;
        tick();
        wren = 1'b0;
        #1;
        chk("post_rst_idle_drop", 32'(drop_err), 32'd1);
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        // Fresh frame from IDLE after reset
        do_start();
        steady_frame("f4", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
